// File: rtl/player_bullet_ctrl.sv
// Single player bullet: launches on a fire press, climbs one step per frame tick,
// retires on a hit or on leaving the top of the playfield, then waits out a cooldown.
module player_bullet_ctrl #(
    parameter int BULLET_SPEED   = 4,
    parameter int TOP_Y          = 0,
    parameter int MUZZLE_OFFSET  = 10,
    parameter int X_MAX          = 639,
    parameter int COOLDOWN_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       fire,
    input  logic [9:0] player_x,
    input  logic [8:0] player_y,
    input  logic       collision,
    output logic [9:0] bullet_x,
    output logic [8:0] bullet_y,
    output logic       bullet_active,
    output logic       hit_pulse,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, FLYING, HIT, COOLDOWN} state_t;

    localparam logic [10:0] MUZZLE_W   = 11'(MUZZLE_OFFSET);
    localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
    localparam logic [9:0]  MISS_LIMIT = 10'(TOP_Y + BULLET_SPEED);
    localparam logic [8:0]  SPEED_W    = 9'(BULLET_SPEED);
    localparam logic [7:0]  COOL_W     = 8'(COOLDOWN_TICKS);

    state_t     state_q, state_d;
    logic [9:0] bullet_x_q, bullet_x_d;
    logic [8:0] bullet_y_q, bullet_y_d;
    logic       active_q, active_d;
    logic       hit_q, hit_d;
    logic       busy_q, busy_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fire_dly_q, fire_dly_d;

    logic [10:0] launch_sum;
    logic [9:0]  launch_x;
    logic        fire_rise;

    // Sum kept 11 bits wide so the clamp sees the true value instead of a wrapped one.
    assign launch_sum = {1'b0, player_x} + MUZZLE_W;
    assign launch_x   = (launch_sum > X_MAX_W) ? X_MAX_W[9:0] : launch_sum[9:0];
    assign fire_rise  = fire & ~fire_dly_q;

    always_comb begin
        state_d    = state_q;
        bullet_x_d = bullet_x_q;
        bullet_y_d = bullet_y_q;
        active_d   = active_q;
        hit_d      = 1'b0;
        cnt_d      = cnt_q;
        fire_dly_d = fire;

        case (state_q)
            IDLE: begin
                if (fire_rise) begin
                    bullet_x_d = launch_x;
                    bullet_y_d = player_y;
                    active_d   = 1'b1;
                    state_d    = FLYING;
                end
            end
            FLYING: begin
                if (collision) begin
                    active_d = 1'b0;
                    hit_d    = 1'b1;
                    state_d  = HIT;
                end else if (tick && ({1'b0, bullet_y_q} < MISS_LIMIT)) begin
                    // Retire before subtracting so bullet_y never underflows.
                    active_d = 1'b0;
                    cnt_d    = COOL_W;
                    state_d  = COOLDOWN;
                end else if (tick) begin
                    bullet_y_d = bullet_y_q - SPEED_W;
                end
            end
            HIT: begin
                cnt_d   = COOL_W;
                state_d = COOLDOWN;
            end
            COOLDOWN: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bullet_x_q <= '0;
            bullet_y_q <= '0;
            active_q   <= 1'b0;
            hit_q      <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            // A button held through reset is not a fresh press once reset lifts.
            fire_dly_q <= fire;
        end else begin
            state_q    <= state_d;
            bullet_x_q <= bullet_x_d;
            bullet_y_q <= bullet_y_d;
            active_q   <= active_d;
            hit_q      <= hit_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            fire_dly_q <= fire_dly_d;
        end
    end

    assign bullet_x      = bullet_x_q;
    assign bullet_y      = bullet_y_q;
    assign bullet_active = active_q;
    assign hit_pulse     = hit_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Directed scenarios plus a randomized run, all checked against a cycle-level
// behavioural model of the bullet's life (launch, flight, hit, cooldown).
module tb_player_bullet_ctrl;

    localparam int SPEED = 4;
    localparam int TOPY  = 0;
    localparam int MUZZ  = 10;
    localparam int XMAX  = 639;
    localparam int COOL  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] player_x = '0;
    logic [8:0] player_y = '0;
    logic       collision = 1'b0;
    logic [9:0] bullet_x;
    logic [8:0] bullet_y;
    logic       bullet_active;
    logic       hit_pulse;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Model state: what the bullet is doing, where it is, how long cooldown has left.
    bit m_flying, m_hit, m_cooling, m_fire_prev;
    int m_cnt, m_x, m_y;

    player_bullet_ctrl #(
        .BULLET_SPEED(SPEED), .TOP_Y(TOPY), .MUZZLE_OFFSET(MUZZ),
        .X_MAX(XMAX), .COOLDOWN_TICKS(COOL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .fire(fire),
        .player_x(player_x), .player_y(player_y), .collision(collision),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
        .hit_pulse(hit_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        bit rise;
        if (!rst_n) begin
            m_flying = 0; m_hit = 0; m_cooling = 0; m_cnt = 0; m_x = 0; m_y = 0;
            m_fire_prev = fire;
        end else begin
            rise = fire && !m_fire_prev;
            m_fire_prev = fire;
            if (m_hit) begin
                m_hit = 0; m_cooling = 1; m_cnt = COOL;
            end else if (m_flying) begin
                if (collision) begin
                    m_flying = 0; m_hit = 1;
                end else if (tick && m_y < TOPY + SPEED) begin
                    m_flying = 0; m_cooling = 1; m_cnt = COOL;
                end else if (tick) begin
                    m_y = m_y - SPEED;
                end
            end else if (m_cooling) begin
                if (m_cnt == 0) m_cooling = 0;
                else if (tick) m_cnt = m_cnt - 1;
            end else if (rise) begin
                m_x = (int'(player_x) + MUZZ > XMAX) ? XMAX : int'(player_x) + MUZZ;
                m_y = int'(player_y);
                m_flying = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        fire = 0; tick = 0; collision = 0; rst_n = 0;
        step();
        rst_n = 1;
        step();
    endtask

    task automatic launch(input int px, input int py);
        player_x = 10'(px); player_y = 9'(py); fire = 1;
        step();
        fire = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; fire = 1; collision = 0;
        for (int i = 0; i < 3; i++) begin
            tick = i[0];
            step();
            checks++;
            if ({bullet_x, bullet_y, bullet_active, hit_pulse, busy} !== 22'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got x=%0d y=%0d a=%0b h=%0b b=%0b, need all 0",
                         i, bullet_x, bullet_y, bullet_active, hit_pulse, busy);
            end
        end
        rst_n = 1; tick = 0;
        step(); step();
        checks++;
        if (bullet_active !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_fire: got active=%0b busy=%0b, need 0 0", bullet_active, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_launch_move();
        do_reset();
        launch(300, 440);
        checks++;
        if (bullet_active !== 1'b1 || bullet_x !== 10'd310 || bullet_y !== 9'd440) begin
            errors++;
            $display("FAIL launch: got a=%0b x=%0d y=%0d, need 1 310 440", bullet_active, bullet_x, bullet_y);
        end
        for (int i = 0; i < 3; i++) begin
            tick = 1; step(); tick = 0; step();
        end
        checks++;
        if (bullet_y !== 9'd428) begin
            errors++;
            $display("FAIL move3: got y=%0d, need 428", bullet_y);
        end
        step(); step(); step();
        checks++;
        if (bullet_y !== 9'd428 || bullet_x !== 10'd310 || bullet_active !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_tick: got x=%0d y=%0d a=%0b, need 310 428 1", bullet_x, bullet_y, bullet_active);
        end
        $display("test_launch_move done");
    endtask

    task automatic test_miss_cooldown();
        do_reset();
        launch(50, 10);
        tick = 1; step();
        checks++;
        if (bullet_y !== 9'd6) begin errors++; $display("FAIL miss_y6: got %0d, need 6", bullet_y); end
        step();
        checks++;
        if (bullet_y !== 9'd2) begin errors++; $display("FAIL miss_y2: got %0d, need 2", bullet_y); end
        step();
        tick = 0;
        checks++;
        if (bullet_active !== 1'b0 || bullet_y !== 9'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL miss_retire: got a=%0b y=%0d busy=%0b, need 0 2 1", bullet_active, bullet_y, busy);
        end
        fire = 1; step(); fire = 0; step();
        checks++;
        if (bullet_active !== 1'b0) begin errors++; $display("FAIL cooldown_fire: got a=%0b, need 0", bullet_active); end
        for (int k = 1; k <= 8; k++) begin
            tick = 1; step(); tick = 0;
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL cool_tick%0d: got busy=%0b, need 1", k, busy); end
            step();
            checks++;
            if (busy !== (k < 8)) begin
                errors++;
                $display("FAIL cool_after%0d: got busy=%0b, need %0b", k, busy, k < 8);
            end
        end
        launch(100, 300);
        checks++;
        if (bullet_active !== 1'b1 || bullet_x !== 10'd110) begin
            errors++;
            $display("FAIL relaunch: got a=%0b x=%0d, need 1 110", bullet_active, bullet_x);
        end
        $display("test_miss_cooldown done");
    endtask

    task automatic test_hit();
        do_reset();
        launch(20, 200);
        collision = 1; tick = 1; step(); tick = 0;
        checks++;
        if (hit_pulse !== 1'b1 || bullet_y !== 9'd200 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL hit: got h=%0b y=%0d a=%0b, need 1 200 0", hit_pulse, bullet_y, bullet_active);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (hit_pulse !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hit_once cycle %0d: got h=%0b busy=%0b, need 0 1", i, hit_pulse, busy);
            end
        end
        collision = 0;
        $display("test_hit done");
    endtask

    task automatic test_clamp_hold();
        do_reset();
        player_x = 10'd635; player_y = 9'd20; fire = 1;
        step();
        checks++;
        if (bullet_x !== 10'd639 || bullet_active !== 1'b1) begin
            errors++;
            $display("FAIL clamp: got x=%0d a=%0b, need 639 1", bullet_x, bullet_active);
        end
        tick = 1;
        for (int i = 0; i < 40; i++) step();
        tick = 0;
        step(); step();
        checks++;
        if (bullet_active !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_no_repeat: got a=%0b busy=%0b, need 0 0", bullet_active, busy);
        end
        fire = 0; step(); fire = 1; step(); fire = 0;
        checks++;
        if (bullet_active !== 1'b1) begin errors++; $display("FAIL refire: got a=%0b, need 1", bullet_active); end
        $display("test_clamp_hold done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        launch(40, 300);
        rst_n = 0; step(); rst_n = 1;
        checks++;
        if ({bullet_x, bullet_y, bullet_active, hit_pulse, busy} !== 22'd0) begin
            errors++;
            $display("FAIL reset_flight: got x=%0d y=%0d a=%0b busy=%0b, need all 0", bullet_x, bullet_y, bullet_active, busy);
        end
        launch(40, 5);
        tick = 1; step(); step(); tick = 0;
        checks++;
        if (busy !== 1'b1 || bullet_active !== 1'b0) begin
            errors++;
            $display("FAIL reach_cool: got busy=%0b a=%0b, need 1 0", busy, bullet_active);
        end
        rst_n = 0; step(); rst_n = 1;
        checks++;
        if ({bullet_x, bullet_y, bullet_active, hit_pulse, busy} !== 22'd0) begin
            errors++;
            $display("FAIL reset_cool: got x=%0d y=%0d a=%0b busy=%0b, need all 0", bullet_x, bullet_y, bullet_active, busy);
        end
        step();
        launch(7, 77);
        checks++;
        if (bullet_active !== 1'b1 || bullet_x !== 10'd17 || bullet_y !== 9'd77) begin
            errors++;
            $display("FAIL post_reset_launch: got a=%0b x=%0d y=%0d, need 1 17 77", bullet_active, bullet_x, bullet_y);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [21:0] exp_v;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            tick      = ($urandom_range(0, 2) == 0);
            collision = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) fire = ~fire;
            player_x  = 10'($urandom_range(0, 1023));
            player_y  = 9'($urandom_range(0, 511));
            step();
            exp_v = {10'(m_x), 9'(m_y), m_flying, m_hit, (m_flying || m_hit || m_cooling)};
            checks++;
            if ({bullet_x, bullet_y, bullet_active, hit_pulse, busy} !== exp_v) begin
                errors++;
                $display("FAIL random cycle %0d: got x=%0d y=%0d a=%0b h=%0b b=%0b, need x=%0d y=%0d a=%0b h=%0b b=%0b",
                         i, bullet_x, bullet_y, bullet_active, hit_pulse, busy,
                         exp_v[21:12], exp_v[11:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
        rst_n = 1;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_launch_move();
        test_miss_cooldown();
        test_hit();
        test_clamp_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
